// File: rtl/spi_slave_byte_if.sv
// Pin and local-side signals of the byte-wide SPI slave.
// The slave modport is the responder itself; master is the SPI master plus local logic.
interface spi_slave_byte_if;
  logic       cpol;
  logic       cpha;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] dataIn;
  logic       load;
  logic [7:0] dataOut;
  logic       rx_valid;
  logic       busy;
  logic       tx_empty;
  logic       underrun;

  modport slave (
    input  cpol, cpha, ss, sclk, mosi, dataIn, load,
    output miso, miso_oe, dataOut, rx_valid, busy, tx_empty, underrun
  );

  modport master (
    output cpol, cpha, ss, sclk, mosi, dataIn, load,
    input  miso, miso_oe, dataOut, rx_valid, busy, tx_empty, underrun
  );
endinterface

// File: rtl/spi_slave_byte.sv
// Byte-oriented SPI slave, all four CPOL/CPHA modes, with oversampled pins.
// A tx holding register is consumed at every byte start; received bytes are posted with a pulse.
module spi_slave_byte (
  input  logic              clk,
  input  logic              reset,
  spi_slave_byte_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] dout_q, dout_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_empty_q, tx_empty_d;
  logic       underrun_q, underrun_d;
  logic       start_pend_q, start_pend_d;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic lead_edge, trail_edge, samp_edge, drv_edge;
  logic byte_start;
  logic [7:0] rx_next;

  // Bit [0] is s1, [1] is s2, [2] is s3; edges compare s2 against s3.
  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_fall    = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise    = ss_sync_q[1] & ~ss_sync_q[2];
  assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge = cpol_q ? sclk_rise : sclk_fall;
  assign samp_edge  = cpha_q ? trail_edge : lead_edge;
  assign drv_edge   = cpha_q ? lead_edge : trail_edge;
  assign rx_next    = {rx_sr_q[6:0], mosi_sync_q[1]};

  always_comb begin
    state_d      = state_q;
    sclk_sync_d  = {sclk_sync_q[1:0], bus.sclk};
    ss_sync_d    = {ss_sync_q[1:0], bus.ss};
    mosi_sync_d  = {mosi_sync_q[0], bus.mosi};
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    cnt_d        = cnt_q;
    rx_sr_d      = rx_sr_q;
    tx_sr_d      = tx_sr_q;
    hold_d       = hold_q;
    dout_d       = dout_q;
    rx_valid_d   = 1'b0;
    tx_empty_d   = tx_empty_q;
    underrun_d   = underrun_q;
    start_pend_d = 1'b0;
    byte_start   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        // Any sclk edge seen in the same cycle as the select is dropped here.
        if (ss_fall) begin
          state_d    = SHIFT;
          cpol_d     = bus.cpol;
          cpha_d     = bus.cpha;
          byte_start = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          byte_start = start_pend_q;
          if (samp_edge) begin
            rx_sr_d = rx_next;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              dout_d       = rx_next;
              rx_valid_d   = 1'b1;
              start_pend_d = 1'b1;
            end
          end else if (drv_edge && cnt_q != 3'd0) begin
            // A drive edge at count 0 would discard the freshly loaded MSB:
            // the first leading edge with cpha=1, or the last trailing edge with cpha=0.
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.load) begin
      hold_d     = bus.dataIn;
      tx_empty_d = 1'b0;
      underrun_d = 1'b0;
    end

    // The consume sees the pre-load holding value; a same-cycle load stays pending.
    if (byte_start) begin
      if (!tx_empty_q) begin
        tx_sr_d = hold_q;
        if (!bus.load) tx_empty_d = 1'b1;
      end else begin
        tx_sr_d    = 8'hFF;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sclk_sync_q  <= 3'b000;
      ss_sync_q    <= 3'b000;
      mosi_sync_q  <= 2'b00;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      cnt_q        <= 3'd0;
      rx_sr_q      <= 8'h00;
      tx_sr_q      <= 8'h00;
      hold_q       <= 8'h00;
      dout_q       <= 8'h00;
      rx_valid_q   <= 1'b0;
      tx_empty_q   <= 1'b1;
      underrun_q   <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      ss_sync_q    <= ss_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      cnt_q        <= cnt_d;
      rx_sr_q      <= rx_sr_d;
      tx_sr_q      <= tx_sr_d;
      hold_q       <= hold_d;
      dout_q       <= dout_d;
      rx_valid_q   <= rx_valid_d;
      tx_empty_q   <= tx_empty_d;
      underrun_q   <= underrun_d;
      start_pend_q <= start_pend_d;
    end
  end

  assign bus.miso     = (state_q == SHIFT) & tx_sr_q[7];
  assign bus.miso_oe  = (state_q == SHIFT);
  assign bus.busy     = (state_q == SHIFT) && (cnt_q != 3'd0);
  assign bus.dataOut  = dout_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_empty = tx_empty_q;
  assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: a behavioural SPI master at clk/8 plus a receive scoreboard.
module tb_spi_slave_byte;
  localparam int H = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_byte_if bus ();
  spi_slave_byte dut (.clk(clk), .reset(reset), .bus(bus));

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] last_rx = 8'h00;
  logic [7:0] mi;
  logic       st;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Every rx_valid pulse must match the next byte the master sent in full.
  always @(negedge clk) begin
    if (!reset && bus.rx_valid === 1'b1) begin
      if (rx_q.size() == 0) chk("rx_unexpected", 8'(bus.rx_valid), 8'd0);
      else                  chk("dataOut", bus.dataOut, rx_q.pop_front());
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"},     8'(bus.miso),     8'd0);
    chk({tag, "_miso_oe"},  8'(bus.miso_oe),  8'd0);
    chk({tag, "_dataOut"},  bus.dataOut,      8'h00);
    chk({tag, "_rx_valid"}, 8'(bus.rx_valid), 8'd0);
    chk({tag, "_busy"},     8'(bus.busy),     8'd0);
    chk({tag, "_tx_empty"}, 8'(bus.tx_empty), 8'd1);
    chk({tag, "_underrun"}, 8'(bus.underrun), 8'd0);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    bus.dataIn = v;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic ss_lo(input logic pol, input logic pha);
    bus.cpol = pol;
    bus.cpha = pha;
    bus.sclk = pol;
    repeat (H) @(negedge clk);
    bus.ss = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic ss_hi();
    repeat (H) @(negedge clk);
    bus.ss = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // Master side: miso is taken at the sample edge and one clk before it to check stability.
  task automatic spi_byte(input logic [7:0] mo, input int nbits,
                          output logic [7:0] rx, output logic stable);
    logic a, b;
    rx = 8'h00;
    stable = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      if (!bus.cpha) begin
        bus.mosi = mo[3'(7 - k)];
        repeat (H - 1) @(negedge clk);
        a = bus.miso;
        @(negedge clk);
        b = bus.miso;
        bus.sclk = ~bus.cpol;
        repeat (H) @(negedge clk);
        bus.sclk = bus.cpol;
      end else begin
        bus.sclk = ~bus.cpol;
        bus.mosi = mo[3'(7 - k)];
        repeat (H - 1) @(negedge clk);
        a = bus.miso;
        @(negedge clk);
        b = bus.miso;
        bus.sclk = bus.cpol;
        repeat (H) @(negedge clk);
      end
      rx = {rx[6:0], b};
      if (a !== b) stable = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_mi, input string tag);
    logic [7:0] r;
    logic       s;
    rx_q.push_back(mo);
    last_rx = mo;
    spi_byte(mo, 8, r, s);
    chk({tag, "_miso_byte"}, r, exp_mi);
    chk({tag, "_miso_stable"}, 8'(s), 8'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.ss = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.dataIn = 8'h00; bus.load = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Underrun: nothing loaded, master sees all ones.
    ss_lo(1'b0, 1'b0);
    chk("udr_set", 8'(bus.underrun), 8'd1);
    xfer(8'h77, 8'hFF, "udr");
    ss_hi();
    chk("udr_sticky", 8'(bus.underrun), 8'd1);
    chk("udr_miso_idle", 8'(bus.miso), 8'd0);

    // Mode 0 exchange.
    chk("m0_txe_pre", 8'(bus.tx_empty), 8'd1);
    do_load(8'hA5);
    chk("udr_clr", 8'(bus.underrun), 8'd0);
    chk("m0_txe_load", 8'(bus.tx_empty), 8'd0);
    ss_lo(1'b0, 1'b0);
    chk("m0_txe_start", 8'(bus.tx_empty), 8'd1);
    chk("m0_oe_on", 8'(bus.miso_oe), 8'd1);
    xfer(8'h3C, 8'hA5, "m0");
    ss_hi();
    chk("m0_oe_off", 8'(bus.miso_oe), 8'd0);
    chk("m0_dataOut", bus.dataOut, 8'h3C);

    // Modes 1..3.
    for (int m = 1; m < 4; m++) begin
      do_load(8'h5A);
      ss_lo(m[1], m[0]);
      xfer(8'hC3, 8'h5A, $sformatf("mode%0d", m));
      ss_hi();
    end
    chk("modes_dataOut", bus.dataOut, 8'hC3);

    // Back-to-back bytes, second load while byte 1 is in flight.
    do_load(8'h01);
    ss_lo(1'b0, 1'b0);
    fork
      xfer(8'hF0, 8'h01, "b2b1");
      begin
        repeat (20) @(negedge clk);
        do_load(8'h02);
        chk("b2b_txe_loaded", 8'(bus.tx_empty), 8'd0);
      end
    join
    xfer(8'h0F, 8'h02, "b2b2");
    ss_hi();
    chk("b2b_drained", 8'(rx_q.size()), 8'd0);
    chk("b2b_udr_after", 8'(bus.underrun), 8'd1);

    // Abort after 5 bits.
    do_load(8'h66);
    ss_lo(1'b0, 1'b0);
    spi_byte(8'hAA, 5, mi, st);
    chk("abort_busy_mid", 8'(bus.busy), 8'd1);
    chk("abort_miso_bits", mi, 8'h0C);
    ss_hi();
    chk("abort_busy", 8'(bus.busy), 8'd0);
    chk("abort_oe", 8'(bus.miso_oe), 8'd0);
    chk("abort_dataOut", bus.dataOut, last_rx);
    do_load(8'h3E);
    ss_lo(1'b0, 1'b0);
    xfer(8'h81, 8'h3E, "post_abort");
    ss_hi();

    // Reset mid-byte, mode 2, holding empty so underrun is set going in.
    ss_lo(1'b1, 1'b0);
    spi_byte(8'h5C, 4, mi, st);
    chk("rst_pre_udr", 8'(bus.underrun), 8'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_resume", 8'(bus.miso_oe), 8'd0);
    ss_hi();
    do_load(8'hB7);
    ss_lo(1'b1, 1'b0);
    xfer(8'hE1, 8'hB7, "post_rst");
    ss_hi();

    chk("rx_drained", 8'(rx_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_slave_byte.md
# spi_slave_byte

Byte-oriented SPI slave (responder): the receive/transmit counterpart of the team's SPI master, for the far end of the same 4-wire link. It oversamples the incoming `sclk`, `ss` and `mosi` in the local `clk` domain, shifts bytes MSB-first in all four CPOL/CPHA modes, and exchanges parallel bytes with local logic through a load/valid handshake. It replies with a holding-register byte and receives a full-duplex byte on every 8 SPI clocks.

## Interface
- No parameters; data width fixed at 8.
- `clk` input 1: system clock; all logic on posedge; must run at least 8x the `sclk` frequency.
- `reset` input 1: asynchronous, active-high reset.
- `cpol` input 1: SPI clock idle level; static while `ss` is high, captured at `ss` fall.
- `cpha` input 1: 0 = sample on leading edge, 1 = sample on trailing edge; captured at `ss` fall.
- `ss` input 1: slave select, active-low, asynchronous to `clk`.
- `sclk` input 1: SPI clock from the master, asynchronous.
- `mosi` input 1: serial data from the master, asynchronous.
- `miso` output 1: serial data to the master.
- `miso_oe` output 1: tri-state enable for the `miso` pad; 1 only while selected.
- `dataIn` input 8: transmit byte.
- `load` input 1: single-cycle strobe; writes `dataIn` into the tx holding register.
- `dataOut` output 8: last complete received byte.
- `rx_valid` output 1: one-cycle pulse when `dataOut` updates.
- `busy` output 1: high while selected and mid-byte (bit count 1..7).
- `tx_empty` output 1: tx holding register has no unconsumed byte.
- `underrun` output 1: sticky; a byte started with `tx_empty`=1; cleared by `load`.

## Operation
- Synchronizers: `sclk`, `ss` and `mosi` each pass through 2 flops (s1, s2), plus a third stage on `sclk`/`ss` for edge detection.
  - An edge is detected when s2 differs from s3.
- Leading edge: synced `sclk` leaves the `cpol` level. Trailing edge: synced `sclk` returns to it.
- States:
  - IDLE: synced `ss`=1. `miso_oe`=0, bit counter=0. Transition to SHIFT on detected `ss` fall. On that fall, capture `cpol`/`cpha` and perform a byte start.
  - SHIFT: selected.
    - Sample edge (leading if `cpha`=0, trailing if `cpha`=1): `rx_sr <= {rx_sr[6:0], mosi_s2}`, counter+1.
    - Drive edge (the other edge): `tx_sr <= tx_sr << 1`.
    - Exception for `cpha`=1: the first leading edge of a byte does not shift, because the MSB is already presented.
  - Transition to IDLE on detected `ss` rise, from any bit count.
- Byte start (on `ss` fall, and on the cycle after the 8th sample while still selected):
  - Holding register has data: `tx_sr <= holding`, `tx_empty <= 1`.
  - Holding register empty: `tx_sr <= 8'hFF`, `underrun <= 1`.
- `miso` = `tx_sr[7]` while in SHIFT; 0 in IDLE.
- After the 8th sample: `dataOut <= {rx_sr[6:0], mosi_s2}`, `rx_valid` pulses, counter wraps to 0. Back-to-back bytes need no `ss` toggle.
- Boundary conditions:
  - `load` while `tx_empty`=0: overwrite the holding register. There is no overrun flag.
  - `load` in the same cycle as a byte-start consume: the old value goes to `tx_sr`; the new value stays in holding; `tx_empty` stays 0.
  - `ss` rise mid-byte: partial byte discarded, no `rx_valid`, `dataOut` unchanged. The consumed tx byte is lost.
  - `ss` fall and an `sclk` edge detected in the same cycle: the `ss` fall wins and the `sclk` edge is ignored. Masters must leave at least 4 `clk` of setup.
  - `reset` mid-byte: all state cleared immediately; shift resumes only on a fresh `ss` fall.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `dataOut`=8'h00, `rx_valid`=0, `busy`=0, `tx_empty`=1, `underrun`=0. State IDLE, all shift registers 0.
- Input-pin edge to detection: 2–3 `clk`. Detection to register update: 1 `clk`.
- `rx_valid`/`dataOut`: valid 1 `clk` after the cycle in which the 8th sample edge is detected.
- `miso` changes 1 `clk` after drive-edge detection, i.e. ≤4 `clk` after the pin edge. This is within a half `sclk` period at the ≥8x ratio.
- `miso_oe` rises/falls 1 `clk` after the `ss` edge is detected.
- `tx_empty` rises 1 `clk` after a byte start. `load` must arrive before the next byte start to avoid `underrun`.

## Test plan
- Mode 0 (cpol=0, cpha=0), `sclk`=clk/8: load 8'hA5, master sends 8'h3C → `dataOut`=8'h3C with a single `rx_valid` pulse; master receives 8'hA5; `tx_empty` 1→0→1.
- Modes 1, 2, 3: same exchange with 8'h5A/8'hC3 → correct bytes both ways in each mode; `miso` stable at every master sample edge.
- Back-to-back: loads 8'h01 then 8'h02 (second during byte 1); master sends 8'hF0, 8'h0F without raising `ss` → two `rx_valid` pulses with 8'hF0 then 8'h0F; master receives 8'h01, 8'h02.
- Underrun: no `load`, one byte clocked → master receives 8'hFF, `underrun`=1; next `load` clears it.
- Abort: `ss` raised after 5 bits → no `rx_valid`, `dataOut` unchanged, `busy`=0, `miso_oe`=0; the next full byte is received correctly.
- `reset` asserted mid-byte → all outputs at reset values on the following edge; a subsequent transfer works normally.
